regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the LA32R pipeline; successor to the single-write, two-read register file. Provides `NRD` combinational read ports and `NWR` clocked write ports with per-byte write enables. Includes a per-register pending-write scoreboard used by decode for RAW hazard detection. Register 0 is hardwired to zero. Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- `DATA_W`, 32, register width in bits; must be a multiple of 8.
- `ADDR_W`, 5, address width; the file holds 2^ADDR_W registers.
- `NRD`, 2, number of read ports (≥1).
- `NWR`, 2, number of write ports (≥1).

Ports (bus slices are packed, port *i* at bits [i*W +: W]):
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `raddr`  in  NRD*ADDR_W  read addresses.
- `rdata`  out  NRD*DATA_W  read data.
- `rbusy`  out  NRD  scoreboard bit of the addressed register.
- `we`  in  NWR*(DATA_W/8)  per-port byte write enables, high active.
- `waddr`  in  NWR*ADDR_W  write addresses.
- `wdata`  in  NWR*DATA_W  write data.
- `sb_set`  in  1  mark `sb_addr` as having a pending write.
- `sb_addr`  in  ADDR_W  register to mark busy.
- `sb_full`  out  1  high when every register 1..2^ADDR_W-1 is busy.

## Operation
- Storage: 2^ADDR_W × DATA_W flops. Entry 0 always reads 0, never busy; writes and sets to 0 are ignored.
- Write: for each port *j* and byte *b* with `we[j][b]`=1, byte *b* of `waddr[j]` takes `wdata[j]` byte *b* at the clock edge. Bytes with enable low keep their old value.
- Write conflict: if several ports write the same byte of the same register in one cycle, the highest-index port wins. This is resolved per byte, so disjoint byte lanes from different ports merge.
- Read: `rdata[i]` is a combinational function of `raddr[i]` and the stored array.
- Scoreboard:
  - Clear: any write port with `we[j]`≠0 clears busy for `waddr[j]` (writeback completion).
  - Set: `sb_set`=1 sets busy for `sb_addr`.
  - Same register set and cleared in the same cycle: set wins, because it marks a new producer.
  - `rbusy[i]` = busy[`raddr[i]`].
- `sb_full` is combinational from the busy vector.

## Timing
- Reset (`resetn` low, asynchronous): all registers become 0 and all busy bits become 0 immediately.
  - Outputs during reset: `rdata`=0, `rbusy`=0, `sb_full`=0.
  - Reset release is synchronised externally; no write is taken on a cycle where `resetn` is low.
- Write latency: 1 cycle. Data written at edge *n* is visible on `rdata` after edge *n* (combinational path).
- Read latency: 0 cycles (combinational).
- Scoreboard latency: `sb_set` at edge *n* makes `rbusy` high after edge *n*. A clear at edge *n* drops it after edge *n*.
- Reset mid-operation discards all in-flight writes and pending bits.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Each read port forwards same-cycle write data per byte, applying the same highest-index-wins rule as the write conflict rule, so `rdata` equals the post-edge value.
  - `rbusy[i]` is suppressed when the addressed register is being cleared this cycle and `sb_set` does not target it.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return the pre-edge stored value.
  - `rbusy` reflects only the stored busy bit.

## Test plan
- Reset, then write 0xDEADBEEF to r5 on port 0 with `we`=0xF → next cycle `rdata[0]` with `raddr`=5 reads 0xDEADBEEF. Read of r0 = 0. Write 0x1234 to r0 → r0 still reads 0.
- Byte enables: r7=0x11223344, then port 1 writes 0xAABBCCDD with `we`=0b0101 → r7 = 0x11BB33DD.
- Conflict: port 0 writes r3=0xFFFFFFFF with `we`=0xF and port 1 writes r3=0x00000000 with `we`=0x3 in the same cycle → r3 = 0xFFFF0000.
- Scoreboard: `sb_set` r9 → `rbusy`=1. Write r9 → `rbusy`=0. Set r9 and write r9 in the same cycle → `rbusy` stays 1. Set all of r1..r31 → `sb_full`=1.
- Bypass: write r4=0xCAFEF00D while reading r4 in the same cycle → `rdata`=0xCAFEF00D with `REGFILE_BYPASS_EN` defined, and the old value (0 after reset) without it.
- Async reset: assert `resetn` low between edges after several writes and sets → `rdata` and `rbusy` are 0 immediately, before the next edge.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port LA32R register file with byte write enables and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and scoreboard clears to the read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NRD*ADDR_W-1:0]      raddr,
  output logic [NRD*DATA_W-1:0]      rdata,
  output logic [NRD-1:0]             rbusy,
  input  logic [NWR*(DATA_W/8)-1:0]  we,
  input  logic [NWR*ADDR_W-1:0]      waddr,
  input  logic [NWR*DATA_W-1:0]      wdata,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  output logic                       sb_full
);

  localparam int NB   = DATA_W / 8;
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;

  // Ports are visited in ascending order so the last non-blocking update,
  // i.e. the highest-index port, wins each byte lane independently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++)
        for (int unsigned b = 0; b < NB; b++)
          if (we[j*NB+b] && waddr[j*ADDR_W +: ADDR_W] != '0)
            mem[waddr[j*ADDR_W +: ADDR_W]][b*8 +: 8] <= wdata[j*DATA_W + b*8 +: 8];
    end
  end

  // Clears first, then the set, so a new producer overrides a completing writeback.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++)
        if (we[j*NB +: NB] != '0)
          busy[waddr[j*ADDR_W +: ADDR_W]] <= 1'b0;
      if (sb_set && sb_addr != '0)
        busy[sb_addr] <= 1'b1;
    end
  end

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;
  logic              rb;
`ifdef REGFILE_BYPASS_EN
  logic              clr;
`endif

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rv    = '0;
    rb    = 1'b0;
`ifdef REGFILE_BYPASS_EN
    clr   = 1'b0;
`endif
    for (int unsigned i = 0; i < NRD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      rv = mem[ra];
      rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
      clr = 1'b0;
      for (int unsigned j = 0; j < NWR; j++) begin
        if (waddr[j*ADDR_W +: ADDR_W] == ra) begin
          for (int unsigned b = 0; b < NB; b++)
            if (we[j*NB+b]) rv[b*8 +: 8] = wdata[j*DATA_W + b*8 +: 8];
          if (we[j*NB +: NB] != '0) clr = 1'b1;
        end
      end
      if (clr && !(sb_set && sb_addr == ra)) rb = 1'b0;
`endif
      // Writes are not taken while reset is low, so forwarding is gated too.
      if (ra == '0 || !resetn) begin
        rv = '0;
        rb = 1'b0;
      end
      rdata[i*DATA_W +: DATA_W] = rv;
      rbusy[i]                  = rb;
    end
  end

  assign sb_full = &busy[NREG-1:1];

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-based reference model.
// Build with or without REGFILE_BYPASS_EN; expectations follow the same macro.
module tb_regfile_mp;

  localparam int DW = 32, AW = 5, NRD = 2, NWR = 2, NB = 4, NREG = 32;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*DW-1:0]   rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR*NB-1:0]   we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*DW-1:0]   wdata;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                sb_full;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_mem  [NREG];
  logic          m_busy [NREG];

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .sb_set(sb_set), .sb_addr(sb_addr),
    .sb_full(sb_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value register a holds after the coming edge: per byte, the highest enabled port targeting it.
  function automatic logic [DW-1:0] post_val(input int a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
    for (int b = 0; b < NB; b++) begin
      for (int j = NWR - 1; j >= 0; j--) begin
        if (we[j*NB+b] && int'(waddr[j*AW +: AW]) == a) begin
          v[b*8 +: 8] = wdata[j*DW + b*8 +: 8];
          break;
        end
      end
    end
    return v;
  endfunction

  function automatic bit cleared(input int a);
    for (int j = 0; j < NWR; j++)
      if (we[j*NB +: NB] != '0 && int'(waddr[j*AW +: AW]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit set_hit(input int a);
    return sb_set && int'(sb_addr) == a && a != 0;
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    return post_val(a);
`else
    return m_mem[a];
`endif
  endfunction

  function automatic logic exp_rbusy(input int a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    return m_busy[a] && !(cleared(a) && !set_hit(a));
`else
    return m_busy[a];
`endif
  endfunction

  function automatic logic exp_full();
    for (int a = 1; a < NREG; a++) if (!m_busy[a]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < NREG; a++) begin
      m_mem[a]  = '0;
      m_busy[a] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int a = 1; a < NREG; a++) begin
      m_mem[a] = post_val(a);
      if (set_hit(a))      m_busy[a] = 1'b1;
      else if (cleared(a)) m_busy[a] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string ph);
    int a;
    for (int i = 0; i < NRD; i++) begin
      a = int'(raddr[i*AW +: AW]);
      check($sformatf("%s rdata%0d r%0d", ph, i, a), rdata[i*DW +: DW], exp_rdata(a));
      check($sformatf("%s rbusy%0d r%0d", ph, i, a), 32'(rbusy[i]), 32'(exp_rbusy(a)));
    end
    check($sformatf("%s sb_full", ph), 32'(sb_full), 32'(exp_full()));
  endtask

  // Called at posedge+1 with inputs already driven; checks mid-cycle, then commits the edge.
  task automatic step(input string ph);
    #3;
    check_outputs(ph);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d, input logic [NB-1:0] e);
    we[p*NB +: NB]    = e;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    logic [DW-1:0] byp_exp;
    idle();
    raddr = '0;
    model_reset();
    #12;
    check("reset rdata0", rdata[31:0], 32'h0);
    check("reset rbusy", 32'(rbusy), 32'h0);
    check("reset sb_full", 32'(sb_full), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Same-cycle read of a register being written
    wr(0, 4, 32'hCAFEF00D, 4'hF); rd(0, 4); rd(1, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'hCAFEF00D;
`else
    byp_exp = 32'h0;
`endif
    check("bypass r4", rdata[31:0], byp_exp);
    step("byp");

    wr(0, 5, 32'hDEADBEEF, 4'hF); wr(1, 0, 32'h1234, 4'hF); rd(0, 5); rd(1, 0);
    step("w5");
    idle(); rd(0, 5); rd(1, 0); #1;
    check("r5 read", rdata[31:0], 32'hDEADBEEF);
    check("r0 read", rdata[63:32], 32'h0);
    step("w5b");

    wr(0, 7, 32'h11223344, 4'hF); step("w7");
    idle(); wr(1, 7, 32'hAABBCCDD, 4'b0101); rd(0, 7); step("w7be");
    idle(); #1;
    check("r7 byte enables", rdata[31:0], 32'h11BB33DD);
    step("w7c");

    wr(0, 3, 32'hFFFFFFFF, 4'hF); wr(1, 3, 32'h0, 4'h3); rd(1, 3); step("cf");
    idle(); rd(0, 3); #1;
    check("r3 conflict", rdata[31:0], 32'hFFFF0000);
    step("cf2");

    sb_set = 1'b1; sb_addr = 9; rd(0, 9); step("sb");
    idle(); #1;
    check("r9 busy after set", 32'(rbusy[0]), 32'h1);
    step("sb2");
    wr(1, 9, 32'h99, 4'h1); step("sbclr");
    idle(); #1;
    check("r9 idle after write", 32'(rbusy[0]), 32'h0);
    step("sb3");
    sb_set = 1'b1; sb_addr = 9; wr(0, 9, 32'h77, 4'hF); step("sbboth");
    idle(); #1;
    check("r9 set wins", 32'(rbusy[0]), 32'h1);
    step("sb4");

    for (int a = 1; a < NREG; a++) begin
      idle(); sb_set = 1'b1; sb_addr = AW'(a); rd(0, a); rd(1, a - 1);
      step("fill");
    end
    idle(); #1;
    check("sb_full all set", 32'(sb_full), 32'h1);
    step("full");

    for (int n = 0; n < 600; n++) begin
      idle();
      for (int j = 0; j < NWR; j++) begin
        if ($urandom_range(0, 2) != 0)
          wr(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5),
             $urandom, NB'($urandom));
      end
      sb_set  = ($urandom_range(0, 3) == 0);
      sb_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 5)) : AW'($urandom);
      for (int i = 0; i < NRD; i++)
        rd(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5));
      step("rnd");
    end

    // Asynchronous reset between edges with traffic in flight
    idle(); wr(0, 3, 32'h12345678, 4'hF); sb_set = 1'b1; sb_addr = 3; rd(0, 3); rd(1, 9);
    step("prerst");
    wr(1, 3, 32'hA5A5A5A5, 4'hF); sb_set = 1'b1; sb_addr = 9;
    #2;
    resetn = 1'b0;
    #1;
    check("async rst rdata0", rdata[31:0], 32'h0);
    check("async rst rdata1", rdata[63:32], 32'h0);
    check("async rst rbusy", 32'(rbusy), 32'h0);
    check("async rst sb_full", 32'(sb_full), 32'h0);
    model_reset();
    @(posedge clk);
    #2;
    check("in rst rdata0", rdata[31:0], 32'h0);
    check("in rst rbusy", 32'(rbusy), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      rd(0, 3); rd(1, 9);
      if (n == 1) wr(0, 3, 32'h0BADF00D, 4'hC);
      step("postrst");
      idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
